// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types: PC, instruction word and the buffered fetch entry.
// FETCH_DEPTH sets the default fetch FIFO depth.
package fetch_queue_pkg;

   localparam int PC_WIDTH    = 8;
   localparam int INSTR_WIDTH = 32;
   localparam int FETCH_DEPTH = 2;

   typedef logic [PC_WIDTH-1:0]    ProgramCounter;
   typedef logic [INSTR_WIDTH-1:0] Instruction;

   typedef struct packed {
      ProgramCounter pc;
      Instruction    instr;
   } FetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of FetchEntry with flush priority over push/pop.
// Ports: clk, rst, push, pop, flush, din, dout (0 when empty), count, full, empty.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  FetchEntry     din,
   output FetchEntry     dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   FetchEntry       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push}
                        - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= din;
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, drives the ROM address, buffers fetched
// instructions and hands them downstream via out_valid/out_ready.
// Ports: clk, rst, imem_addr/imem_instr (comb ROM), redirect/redirect_pc,
// out_valid/out_ready, out_instr, out_pc, out_next_pc, occupancy.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              PC_W     = PC_WIDTH,
   parameter int              INSTR_W  = INSTR_WIDTH,
   parameter int              DEPTH    = FETCH_DEPTH,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [PC_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]       imem_instr,
   input  logic                     redirect,
   input  logic [PC_W-1:0]          redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic [PC_W-1:0]          out_next_pc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   logic [PC_W-1:0] pc;
   logic            pop;
   logic            fetch;
   logic            full;
   logic            empty;
   FetchEntry       din;
   FetchEntry       dout;

   assign imem_addr = pc;

   // A redirect cycle must never hand over a wrong-path head.
   assign out_valid = !empty && !redirect;
   assign pop       = out_valid && out_ready;
   // A full queue can still fetch when the head leaves this cycle.
   assign fetch     = !redirect && (!full || pop);

   assign din.pc    = pc;
   assign din.instr = imem_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= RESET_PC;
      else if (redirect)
         pc <= redirect_pc;
      else if (fetch)
         pc <= pc + 1'b1;
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fetch),
      .pop   (pop),
      .flush (redirect),
      .din   (din),
      .dout  (dout),
      .count (occupancy),
      .full  (full),
      .empty (empty)
   );

   assign out_instr   = dout.instr;
   assign out_pc      = dout.pc;
   assign out_next_pc = empty ? '0 : dout.pc + 1'b1;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a PC-queue scoreboard model.
// ROM[i] = i + 0x100, combinational.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic [7:0]  imem_addr;
   logic [31:0] imem_instr;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic [7:0]  out_next_pc;
   logic [1:0]  occupancy;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mq [$];
   logic [7:0] mpc;

   fetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_next_pc (out_next_pc),
      .occupancy   (occupancy)
   );

   assign imem_instr = 32'h100 + {24'b0, imem_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check against model, advance model.
   task automatic step(input logic       redir,
                       input logic [7:0] rpc,
                       input logic       rdy);
      logic mv;
      logic mpop;
      logic mfetch;
      @(negedge clk);
      redirect    = redir;
      redirect_pc = rpc;
      out_ready   = rdy;
      #1;
      mv = (mq.size() > 0) && !redir;
      chk("imem_addr", {24'b0, imem_addr}, {24'b0, mpc});
      chk("occupancy", {30'b0, occupancy}, 32'(mq.size()));
      chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
      if (mv) begin
         chk("out_pc", {24'b0, out_pc}, {24'b0, mq[0]});
         chk("out_instr", out_instr, 32'h100 + {24'b0, mq[0]});
         chk("out_next_pc", {24'b0, out_next_pc},
             {24'b0, mq[0] + 8'd1});
      end else if (mq.size() == 0) begin
         chk("empty_pc", {24'b0, out_pc}, 32'h0);
         chk("empty_instr", out_instr, 32'h0);
         chk("empty_next", {24'b0, out_next_pc}, 32'h0);
      end
      mpop   = mv && rdy;
      mfetch = !redir && ((mq.size() < 2) || mpop);
      if (redir) begin
         mq.delete();
         mpc = rpc;
      end else begin
         if (mpop)
            void'(mq.pop_front());
         if (mfetch) begin
            mq.push_back(mpc);
            mpc = mpc + 8'd1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mq.delete();
      mpc = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      out_ready   = 1'b0;
      mpc         = 8'h00;

      #12;
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_occ", {30'b0, occupancy}, 32'h0);
      chk("rst_addr", {24'b0, imem_addr}, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc", {24'b0, out_pc}, 32'h0);
      chk("rst_next", {24'b0, out_next_pc}, 32'h0);

      // Steady stream
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 8'h00, 1'b1);
      chk("c0_valid", {31'b0, out_valid}, 32'h0);
      step(1'b0, 8'h00, 1'b1);
      chk("first_valid", {31'b0, out_valid}, 32'h1);
      chk("first_pc", {24'b0, out_pc}, 32'h0);
      chk("first_instr", out_instr, 32'h100);
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("stream_pc", {24'b0, out_pc}, 32'(i));
         chk("stream_occ", {30'b0, occupancy}, 32'h1);
      end

      // Backpressure from cycle 2
      do_reset();
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("bp_occ", {30'b0, occupancy}, 32'h2);
      chk("bp_addr", {24'b0, imem_addr}, 32'h3);
      step(1'b0, 8'h00, 1'b0);
      chk("bp_addr_hold", {24'b0, imem_addr}, 32'h3);
      for (int p = 1; p <= 3; p++) begin
         step(1'b0, 8'h00, 1'b1);
         chk("bp_order", {24'b0, out_pc}, 32'(p));
      end
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("pre_redir_occ", {30'b0, occupancy}, 32'h2);

      // Redirect while full
      step(1'b1, 8'h40, 1'b1);
      chk("redir_valid", {31'b0, out_valid}, 32'h0);
      step(1'b0, 8'h00, 1'b1);
      chk("redir_addr", {24'b0, imem_addr}, 32'h40);
      chk("redir_gap", {31'b0, out_valid}, 32'h0);
      step(1'b0, 8'h00, 1'b1);
      chk("redir_pc", {24'b0, out_pc}, 32'h40);
      chk("redir_next", {24'b0, out_next_pc}, 32'h41);
      for (int i = 0; i < 3; i++)
         step(1'b0, 8'h00, 1'b1);

      // PC wrap
      step(1'b1, 8'hFE, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_fe", {24'b0, out_pc}, 32'hFE);
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_ff", {24'b0, out_pc}, 32'hFF);
      chk("wrap_next", {24'b0, out_next_pc}, 32'h00);
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_00", {24'b0, out_pc}, 32'h00);
      chk("wrap_valid", {31'b0, out_valid}, 32'h1);

      // Back-to-back redirects: last wins
      step(1'b1, 8'h10, 1'b1);
      step(1'b1, 8'h20, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("b2b_addr", {24'b0, imem_addr}, 32'h20);
      step(1'b0, 8'h00, 1'b1);
      chk("b2b_pc", {24'b0, out_pc}, 32'h20);
      for (int i = 0; i < 3; i++)
         step(1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-stream at occupancy 2
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("pre_rst_occ", {30'b0, occupancy}, 32'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'h0);
      chk("arst_occ", {30'b0, occupancy}, 32'h0);
      chk("arst_addr", {24'b0, imem_addr}, 32'h0);
      mq.delete();
      mpc = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("restart_pc", {24'b0, out_pc}, 32'h0);
      chk("restart_valid", {31'b0, out_valid}, 32'h1);
      for (int i = 0; i < 3; i++)
         step(1'b0, 8'h00, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
